// File: rtl/ddr_rd_arbiter.sv
// ----------------------------------------------------------------------------
// ddr_rd_arbiter
//
// Shares the single DDR read command channel between the weight loader
// (port 0) and the feature-map loader (port 1). One burst is granted at a
// time, round-robin. The granted burst is issued as one read command per
// beat. The returned beats are counted and steered to the owning port.
//
// Ports
//   clk_i, rst_i                 system clock, asynchronous active-high reset
//   reqN_i / addrN_i / lenN_i    burst request (level), start address, beats
//   ackN_o                       one-cycle pulse: request taken, inputs sampled
//   doneN_o                      one-cycle pulse with the last beat of a burst
//   rd_validN_o, rd_data_o       returned beat, valid only for the owner
//   ddr_cmd_en_o/_o/_addr_o      DDR read command (ddr_cmd_o fixed to read)
//   ddr_rdy_i                    DDR command ready
//   ddr_rd_data_valid_i/_data_i  returned beat from the DDR synchroniser
//   err_o                        sticky: a beat arrived with no burst open
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | no burst open; arbitrate, zero-length bursts finish here
// ISSUE | issuing read commands; returned beats are already counted
// DRAIN | all commands accepted; waiting for the remaining beats
// ----------------------------------------------------------------------------
module ddr_rd_arbiter #(
    parameter int DW        = 512,
    parameter int AW        = 30,
    parameter int LW        = 8,
    parameter int ADDR_STEP = 8
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          req0_i,
    input  logic          req1_i,
    input  logic [AW-1:0] addr0_i,
    input  logic [AW-1:0] addr1_i,
    input  logic [LW-1:0] len0_i,
    input  logic [LW-1:0] len1_i,
    output logic          ack0_o,
    output logic          ack1_o,
    output logic          done0_o,
    output logic          done1_o,
    output logic          rd_valid0_o,
    output logic          rd_valid1_o,
    output logic [DW-1:0] rd_data_o,
    output logic          ddr_cmd_en_o,
    output logic [2:0]    ddr_cmd_o,
    output logic [AW-1:0] ddr_addr_o,
    input  logic          ddr_rdy_i,
    input  logic          ddr_rd_data_valid_i,
    input  logic [DW-1:0] ddr_rd_data_i,
    output logic          err_o
);

    localparam logic [AW-1:0] STEP    = AW'(ADDR_STEP);
    localparam logic [2:0]    CMD_RD  = 3'b001;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic          prio_q, prio_d;      // port favoured at the next contention
    logic          owner_q, owner_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [LW:0]   len_q, len_d;
    logic [LW:0]   issued_q, issued_d;
    logic [LW:0]   rcvd_q, rcvd_d;
    logic          cmd_en_q, cmd_en_d;
    logic [1:0]    ack_q, ack_d;
    logic [1:0]    done_q, done_d;
    logic [1:0]    valid_q, valid_d;
    logic [DW-1:0] data_q, data_d;
    logic          err_q, err_d;

    logic [1:0]    req;
    logic          grant_any;
    logic          grant_port;
    logic [AW-1:0] grant_addr;
    logic [LW-1:0] grant_len;
    logic          cmd_acc;
    logic          cmd_last;
    logic          beat_last;

    // Round-robin selection. A grant is suppressed while an ack pulse is
    // still out: the requester only drops req after seeing ack, so the
    // same request would otherwise be granted twice after a zero-length
    // burst, which finishes without leaving IDLE.
    always_comb begin
        req        = {req1_i, req0_i};
        grant_port = req[prio_q] ? prio_q : ~prio_q;
        grant_any  = (|req) && (ack_q == 2'b00);
        grant_addr = grant_port ? addr1_i : addr0_i;
        grant_len  = grant_port ? len1_i : len0_i;
    end

    always_comb begin
        state_d   = state_q;
        prio_d    = prio_q;
        owner_d   = owner_q;
        addr_d    = addr_q;
        len_d     = len_q;
        issued_d  = issued_q;
        rcvd_d    = rcvd_q;
        cmd_en_d  = cmd_en_q;
        ack_d     = 2'b00;
        done_d    = 2'b00;
        valid_d   = 2'b00;
        data_d    = data_q;
        err_d     = err_q;

        cmd_acc   = cmd_en_q & ddr_rdy_i;
        cmd_last  = (issued_q + 1'b1) == len_q;
        beat_last = (rcvd_q + 1'b1) == len_q;

        case (state_q)
            ST_IDLE: begin
                cmd_en_d = 1'b0;
                if (ddr_rd_data_valid_i) begin
                    err_d = 1'b1;
                end
                if (grant_any) begin
                    ack_d[grant_port] = 1'b1;
                    prio_d            = ~grant_port;
                    owner_d           = grant_port;
                    addr_d            = grant_addr;
                    len_d             = {1'b0, grant_len};
                    issued_d          = '0;
                    rcvd_d            = '0;
                    if (grant_len == '0) begin
                        done_d[grant_port] = 1'b1;
                    end else begin
                        state_d = ST_ISSUE;
                    end
                end
            end

            ST_ISSUE: begin
                // cmd_en is raised on the first ISSUE cycle, i.e. the cycle
                // after ack, and held until the last command is taken.
                if (cmd_acc) begin
                    addr_d   = addr_q + STEP;
                    issued_d = issued_q + 1'b1;
                    if (cmd_last) begin
                        cmd_en_d = 1'b0;
                        state_d  = ST_DRAIN;
                    end
                end else begin
                    cmd_en_d = 1'b1;
                end
            end

            ST_DRAIN: begin
                cmd_en_d = 1'b0;
            end

            default: begin
                cmd_en_d = 1'b0;
                state_d  = ST_IDLE;
            end
        endcase

        // Beats may return while commands are still being issued.
        if ((state_q == ST_ISSUE || state_q == ST_DRAIN) && ddr_rd_data_valid_i) begin
            rcvd_d           = rcvd_q + 1'b1;
            valid_d[owner_q] = 1'b1;
            data_d           = ddr_rd_data_i;
            if (beat_last) begin
                done_d[owner_q] = 1'b1;
                cmd_en_d        = 1'b0;
                state_d         = ST_IDLE;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            prio_q   <= 1'b0;
            owner_q  <= 1'b0;
            addr_q   <= '0;
            len_q    <= '0;
            issued_q <= '0;
            rcvd_q   <= '0;
            cmd_en_q <= 1'b0;
            ack_q    <= 2'b00;
            done_q   <= 2'b00;
            valid_q  <= 2'b00;
            data_q   <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            prio_q   <= prio_d;
            owner_q  <= owner_d;
            addr_q   <= addr_d;
            len_q    <= len_d;
            issued_q <= issued_d;
            rcvd_q   <= rcvd_d;
            cmd_en_q <= cmd_en_d;
            ack_q    <= ack_d;
            done_q   <= done_d;
            valid_q  <= valid_d;
            data_q   <= data_d;
            err_q    <= err_d;
        end
    end

    assign ack0_o       = ack_q[0];
    assign ack1_o       = ack_q[1];
    assign done0_o      = done_q[0];
    assign done1_o      = done_q[1];
    assign rd_valid0_o  = valid_q[0];
    assign rd_valid1_o  = valid_q[1];
    assign rd_data_o    = data_q;
    assign ddr_cmd_en_o = cmd_en_q;
    assign ddr_cmd_o    = CMD_RD;
    assign ddr_addr_o   = addr_q;
    assign err_o        = err_q;

endmodule

// File: tb/tb_ddr_rd_arbiter.sv
// ----------------------------------------------------------------------------
// tb_ddr_rd_arbiter
//
// Directed and randomised bursts against ddr_rd_arbiter. A DDR model answers
// every accepted command with one random beat after a configurable latency.
// Expected grant order, command addresses, beat steering and done timing are
// derived from the arbitration rules and compared with logged DUT activity.
// ----------------------------------------------------------------------------
module tb_ddr_rd_arbiter;

    localparam int DW        = 512;
    localparam int AW        = 30;
    localparam int LW        = 8;
    localparam int ADDR_STEP = 8;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b1;
    logic          req0_i = 1'b0;
    logic          req1_i = 1'b0;
    logic [AW-1:0] addr0_i = '0;
    logic [AW-1:0] addr1_i = '0;
    logic [LW-1:0] len0_i = '0;
    logic [LW-1:0] len1_i = '0;
    logic          ack0_o, ack1_o, done0_o, done1_o;
    logic          rd_valid0_o, rd_valid1_o;
    logic [DW-1:0] rd_data_o;
    logic          ddr_cmd_en_o;
    logic [2:0]    ddr_cmd_o;
    logic [AW-1:0] ddr_addr_o;
    logic          ddr_rdy_i = 1'b0;
    logic          ddr_rd_data_valid_i = 1'b0;
    logic [DW-1:0] ddr_rd_data_i = '0;
    logic          err_o;

    ddr_rd_arbiter #(.DW(DW), .AW(AW), .LW(LW), .ADDR_STEP(ADDR_STEP)) dut (
        .clk_i               (clk_i),
        .rst_i               (rst_i),
        .req0_i              (req0_i),
        .req1_i              (req1_i),
        .addr0_i             (addr0_i),
        .addr1_i             (addr1_i),
        .len0_i              (len0_i),
        .len1_i              (len1_i),
        .ack0_o              (ack0_o),
        .ack1_o              (ack1_o),
        .done0_o             (done0_o),
        .done1_o             (done1_o),
        .rd_valid0_o         (rd_valid0_o),
        .rd_valid1_o         (rd_valid1_o),
        .rd_data_o           (rd_data_o),
        .ddr_cmd_en_o        (ddr_cmd_en_o),
        .ddr_cmd_o           (ddr_cmd_o),
        .ddr_addr_o          (ddr_addr_o),
        .ddr_rdy_i           (ddr_rdy_i),
        .ddr_rd_data_valid_i (ddr_rd_data_valid_i),
        .ddr_rd_data_i       (ddr_rd_data_i),
        .err_o               (err_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        int            cyc;
        int            port;
        logic [DW-1:0] data;
    } ev_t;

    int            total = 0;
    int            bad   = 0;
    int            cyc   = 0;
    int            lat   = 5;
    int            rdy_mode  = 0;   // 0: always ready, 1: fixed pattern, 2: random
    int            rdy_start = 0;
    int            prio  = 0;       // reference model: port favoured next
    bit            rdy_pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

    ev_t           ack_q[$];
    ev_t           beat_q[$];
    ev_t           done_q[$];
    int            cmd_cyc_q[$];
    logic [AW-1:0] cmd_q[$];
    logic [DW-1:0] sent_q[$];
    int            pend_due[$];

    bit            hold_chk = 1'b0;
    logic [AW-1:0] prev_addr = '0;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(posedge clk_i) cyc++;

    // Monitor plus DDR model, all on the falling edge.
    always @(negedge clk_i) begin
        ev_t           e;
        logic [DW-1:0] d;
        e.cyc  = cyc;
        e.data = rd_data_o;
        if (ack0_o)      begin e.port = 0; ack_q.push_back(e);  end
        if (ack1_o)      begin e.port = 1; ack_q.push_back(e);  end
        if (rd_valid0_o) begin e.port = 0; beat_q.push_back(e); end
        if (rd_valid1_o) begin e.port = 1; beat_q.push_back(e); end
        if (done0_o)     begin e.port = 0; done_q.push_back(e); end
        if (done1_o)     begin e.port = 1; done_q.push_back(e); end

        if (hold_chk && !rst_i) begin
            chk("hold_cmd_en", ddr_cmd_en_o, 1);
            chk("hold_addr", ddr_addr_o, prev_addr);
        end

        case (rdy_mode)
            0:       ddr_rdy_i = 1'b1;
            1:       ddr_rdy_i = rdy_pat[(cyc - rdy_start) % 6];
            default: ddr_rdy_i = 1'($urandom_range(0, 1));
        endcase

        if (ddr_cmd_en_o && ddr_rdy_i && !rst_i) begin
            cmd_q.push_back(ddr_addr_o);
            cmd_cyc_q.push_back(cyc);
            pend_due.push_back(cyc + lat);
        end
        hold_chk  = ddr_cmd_en_o && !ddr_rdy_i;
        prev_addr = ddr_addr_o;

        for (int k = 0; k < DW / 32; k++) d[k*32 +: 32] = $urandom;
        ddr_rd_data_i = d;
        if (pend_due.size() > 0 && pend_due[0] <= cyc) begin
            void'(pend_due.pop_front());
            ddr_rd_data_valid_i = 1'b1;
            sent_q.push_back(d);
        end else begin
            ddr_rd_data_valid_i = 1'b0;
        end
    end

    task automatic scenario(input string tag, input bit r0, input bit r1,
                            input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                            input logic [LW-1:0] n0, input logic [LW-1:0] n1);
        int            order[$];
        int            blen[$];
        int            last_idx[$];
        int            exp_port[$];
        logic [AW-1:0] exp_addr[$];
        int            ndone, budget, start_cyc, nbeats, p, n;
        longint        a;

        ack_q.delete(); beat_q.delete(); done_q.delete();
        cmd_q.delete(); cmd_cyc_q.delete(); sent_q.delete();

        if (r0 && r1) begin
            order.push_back(prio);
            order.push_back(1 - prio);
        end else if (r1) begin
            order.push_back(1);
        end else begin
            order.push_back(0);
        end
        prio = 1 - order[order.size()-1];

        nbeats = 0;
        foreach (order[i]) begin
            p = order[i];
            n = int'(p == 1 ? n1 : n0);
            a = longint'(p == 1 ? a1 : a0);
            for (int j = 0; j < n; j++) begin
                exp_addr.push_back(AW'((a + longint'(j) * ADDR_STEP) % (longint'(1) << AW)));
                exp_port.push_back(p);
            end
            nbeats += n;
            blen.push_back(n);
            last_idx.push_back(nbeats - 1);
        end

        rdy_start = cyc;
        req0_i = r0; req1_i = r1;
        addr0_i = a0; addr1_i = a1;
        len0_i = n0; len1_i = n1;
        start_cyc = cyc;
        ndone = 0;
        budget = 0;
        while (ndone < order.size() && budget < 3000) begin
            @(negedge clk_i);
            budget++;
            if (ack0_o) req0_i = 1'b0;
            if (ack1_o) req1_i = 1'b0;
            ndone += int'(done0_o) + int'(done1_o);
        end
        repeat (4) @(negedge clk_i);

        chk({tag, ":done_count"}, ndone, order.size());
        chk({tag, ":ack_count"}, ack_q.size(), order.size());
        for (int i = 0; i < order.size() && i < ack_q.size(); i++)
            chk({tag, ":ack_port"}, ack_q[i].port, order[i]);
        if (ack_q.size() > 0)
            chk({tag, ":ack_latency"}, ack_q[0].cyc, start_cyc + 1);

        chk({tag, ":cmd_count"}, cmd_q.size(), exp_addr.size());
        for (int i = 0; i < exp_addr.size() && i < cmd_q.size(); i++)
            chk({tag, ":cmd_addr"}, cmd_q[i], exp_addr[i]);

        chk({tag, ":beat_count"}, beat_q.size(), nbeats);
        for (int i = 0; i < nbeats && i < beat_q.size(); i++) begin
            chk({tag, ":beat_port"}, beat_q[i].port, exp_port[i]);
            if (i < sent_q.size())
                chk({tag, ":beat_data"}, beat_q[i].data, sent_q[i]);
        end

        chk({tag, ":done_events"}, done_q.size(), order.size());
        for (int i = 0; i < order.size() && i < done_q.size(); i++) begin
            chk({tag, ":done_port"}, done_q[i].port, order[i]);
            if (blen[i] == 0) begin
                if (i < ack_q.size())
                    chk({tag, ":done_with_ack"}, done_q[i].cyc, ack_q[i].cyc);
            end else if (last_idx[i] < beat_q.size()) begin
                chk({tag, ":done_with_last"}, done_q[i].cyc, beat_q[last_idx[i]].cyc);
            end
        end

        if (rdy_mode == 0 && blen[0] > 0 && cmd_cyc_q.size() > 0 && ack_q.size() > 0)
            chk({tag, ":cmd_after_ack"}, cmd_cyc_q[0], ack_q[0].cyc + 1);
        chk({tag, ":err"}, err_o, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int nb;
        int budget;
        bit r0, r1;
        logic [AW-1:0] a0, a1;

        repeat (3) @(negedge clk_i);
        chk("rst:ack0", ack0_o, 0);
        chk("rst:ack1", ack1_o, 0);
        chk("rst:done0", done0_o, 0);
        chk("rst:done1", done1_o, 0);
        chk("rst:valid0", rd_valid0_o, 0);
        chk("rst:valid1", rd_valid1_o, 0);
        chk("rst:cmd_en", ddr_cmd_en_o, 0);
        chk("rst:cmd", ddr_cmd_o, 3'b001);
        chk("rst:addr", ddr_addr_o, 0);
        chk("rst:data", rd_data_o, 0);
        chk("rst:err", err_o, 0);
        rst_i = 1'b0;

        lat = 5; rdy_mode = 0;
        scenario("single", 1, 0, 30'h100, 30'h0, 8'd4, 8'd0);
        chk("single:cmd_read", ddr_cmd_o, 3'b001);

        lat = 3;
        scenario("contend1", 1, 1, 30'h1000, 30'h2000, 8'd2, 8'd2);
        scenario("contend2", 1, 1, 30'h3000, 30'h4000, 8'd2, 8'd2);

        rdy_mode = 1; lat = 2;
        scenario("backpressure", 1, 0, 30'h500, 30'h0, 8'd3, 8'd0);

        rdy_mode = 0;
        scenario("zero_len", 0, 1, 30'h0, 30'h40, 8'd0, 8'd0);
        scenario("wrap", 1, 0, 30'h3FFFFFF8, 30'h0, 8'd2, 8'd0);

        rdy_mode = 2;
        for (int it = 0; it < 24; it++) begin
            lat = $urandom_range(1, 6);
            r0 = 1'($urandom_range(0, 1));
            r1 = 1'($urandom_range(0, 1));
            if (!r0 && !r1) r1 = 1'b1;
            a0 = AW'($urandom);
            a1 = AW'($urandom);
            if ($urandom_range(0, 3) == 0) a0 = 30'h3FFFFFF0 + AW'($urandom_range(0, 15));
            scenario("random", r0, r1, a0, a1,
                     LW'($urandom_range(0, 9)), LW'($urandom_range(0, 9)));
        end

        // Reset in the middle of a 4-beat burst.
        rdy_mode = 0; lat = 5;
        req0_i = 1'b1; addr0_i = 30'h200; len0_i = 8'd4;
        nb = 0; budget = 0;
        while (nb < 2 && budget < 200) begin
            @(negedge clk_i);
            budget++;
            if (ack0_o) req0_i = 1'b0;
            nb += int'(rd_valid0_o);
        end
        chk("midrst:beats_before", nb, 2);
        rst_i = 1'b1;
        #1;
        chk("midrst:valid0", rd_valid0_o, 0);
        chk("midrst:done0", done0_o, 0);
        chk("midrst:cmd_en", ddr_cmd_en_o, 0);
        chk("midrst:addr", ddr_addr_o, 0);
        chk("midrst:data", rd_data_o, 0);
        chk("midrst:err_in_reset", err_o, 0);
        #1;
        rst_i = 1'b0;
        prio = 0;
        nb = 0;
        repeat (12) begin
            @(negedge clk_i);
            nb += int'(rd_valid0_o) + int'(rd_valid1_o) + int'(done0_o) + int'(done1_o);
        end
        chk("midrst:no_valid_after", nb, 0);
        chk("midrst:late_beats_drained", pend_due.size(), 0);
        chk("midrst:err_sticky", err_o, 1);
        chk("midrst:data_dropped", rd_data_o, 0);

        rst_i = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0;
        chk("rst2:err_clear", err_o, 0);
        scenario("post_reset", 1, 1, 30'h800, 30'h900, 8'd1, 8'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ddr_rd_arbiter.md
# ddr_rd_arbiter

Two-port read scheduler that shares the single DDR read channel between the weight loader (port 0) and the feature-map loader (port 1). Grants one burst request at a time, round-robin, issues one DDR read command per beat, and counts and steers the returned beats from the synchronised DDR read-data path to the owning port. Sits between the loaders and the DDR command port, downstream of the DDR signal synchroniser.

## Interface
- DW, 512, DDR read data width (one beat per command)
- AW, 30, DDR address width
- LW, 8, burst-length field width (beats)
- ADDR_STEP, 8, address increment per command
- clk_i  in  1  system clock
- rst_i  in  1  reset, asynchronous, active-high
- req0_i / req1_i  in  1  burst request, level, held until matching ack
- addr0_i / addr1_i  in  AW  burst start address, sampled at ack
- len0_i / len1_i  in  LW  burst length in beats, sampled at ack
- ack0_o / ack1_o  out  1  one-cycle pulse: request accepted, inputs sampled
- done0_o / done1_o  out  1  one-cycle pulse: last beat of burst delivered
- rd_valid0_o / rd_valid1_o  out  1  beat valid for that port
- rd_data_o  out  DW  returned beat, shared by both ports
- ddr_cmd_en_o  out  1  command valid
- ddr_cmd_o  out  3  command, always 3'b001 (read)
- ddr_addr_o  out  AW  command address
- ddr_rdy_i  in  1  DDR command ready (synchronised)
- ddr_rd_data_valid_i  in  1  returned beat valid (synchronised)
- ddr_rd_data_i  in  DW  returned beat (synchronised)
- err_o  out  1  sticky: beat received while no burst outstanding

## Operation
- States: IDLE, ISSUE, DRAIN.
- IDLE: if any req, select per round-robin, pulse ackN_o, latch addr/len/owner, go ISSUE. Pointer favours the port not granted last; after reset port 0 has priority.
- len = 0: ack and doneN pulse in the same cycle, no command, pointer advances, stay IDLE.
- ISSUE: ddr_cmd_en_o=1, ddr_addr_o = current address. Command accepted when ddr_cmd_en_o & ddr_rdy_i; on acceptance address += ADDR_STEP, issued count += 1. After last acceptance go DRAIN (cmd_en drops next cycle).
- Beat counting runs in ISSUE and DRAIN: each ddr_rd_data_valid_i increments received count; rd_data_o = ddr_rd_data_i, rd_valid{owner}_o = 1, other port valid 0.
- DRAIN: when received count reaches len (beat arrives), pulse done{owner}_o with that last beat, go IDLE. New grant no earlier than the cycle after done.
- Address arithmetic modulo 2^AW (wraps silently). Counters LW+1 bits; max burst 2^LW-1 beats.
- Beat valid in IDLE: dropped, no port valid, err_o set until reset.
- Beats may arrive during ISSUE before all commands issued; counted normally.

## Timing
- Reset values: all ack/done/valid/cmd_en 0, ddr_cmd_o 3'b001, ddr_addr_o 0, rd_data_o 0, err_o 0, state IDLE, pointer to port 0.
- Reset mid-burst: immediate return to IDLE, outstanding beats arriving afterwards flag err_o.
- ack: registered, asserted the cycle after req seen in IDLE; cmd_en first asserted the cycle after ack.
- Data path: rd_data_o / rd_valid registered, 1 cycle after ddr_rd_data_valid_i.
- done coincident with the last rd_valid beat.
- ddr_rdy_i low holds cmd_en and ddr_addr_o stable.
- Requester must keep req high until ack; dropping req before ack is allowed (no grant issued if low when sampled).

## Test plan
- Single burst: req0, addr 0x100, len 4, rdy always 1, beats returned 5 cycles later -> 4 commands at 0x100,0x108,0x110,0x118; 4 rd_valid0 pulses; done0 with 4th; rd_valid1 never.
- Contention: req0 and req1 both high after reset, len 2 each -> port 0 served first, then port 1; second round with both high -> port 0 again only after port 1 (alternation).
- Backpressure: len 3, ddr_rdy_i toggling 1,0,0,1,0,1 -> cmd_en held, address stable while rdy 0, exactly 3 acceptances.
- Zero length: req1 len 0 -> ack1 and done1 same cycle, no ddr_cmd_en_o.
- Wrap: addr 2^30-8, len 2 -> addresses 0x3FFFFFF8 then 0x0.
- Reset mid-burst: rst_i asserted after 2 of 4 beats, then 2 beats arrive -> outputs at reset values, err_o = 1, no rd_valid.
